// File: rtl/irq_controller.sv
// Interrupt source for the CPU handshake: synchronises and edge-detects external
// lines, latches pending requests, masks them and runs the request/ack/eoi FSM.
module irq_controller #(
   parameter int N_IRQ = 8,
   parameter int VEC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   input  logic             int_ack,
   input  logic             eoi,
   output logic             int_sig,
   output logic [VEC_W-1:0] irq_vector,
   output logic             irq_active,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   s1_q, s1_d;
   logic [N_IRQ-1:0]   s2_q, s2_d;
   logic [N_IRQ-1:0]   s3_q, s3_d;
   logic [N_IRQ-1:0]   pending_q, pending_d;
   logic [N_IRQ-1:0]   mask_q, mask_d;
   logic               int_sig_q, int_sig_d;
   logic [VEC_W-1:0]   irq_vector_q, irq_vector_d;
   logic               irq_active_q, irq_active_d;

   logic [N_IRQ-1:0]   rise;
   logic [N_IRQ-1:0]   req;
   logic [N_IRQ-1:0]   clr;
   logic [VEC_W-1:0]   sel_idx;

   always_comb begin
      s1_d = irq_in;
      s2_d = s1_q;
      s3_d = s2_q;
      rise = s2_q & ~s3_q;
      req  = pending_q & ~mask_q;

      // Descending scan so the lowest set index is the one left in sel_idx.
      sel_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req[i]) sel_idx = VEC_W'(i);
      end

      clr = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         clr[i] = (state_q == REQ) && int_ack && (irq_vector_q == VEC_W'(i));
      end

      // Set is applied after clear so a fresh edge survives its own ack.
      pending_d = (pending_q & ~clr) | rise;
      mask_d    = mask_we ? mask_wdata : mask_q;

      state_d      = state_q;
      int_sig_d    = int_sig_q;
      irq_vector_d = irq_vector_q;
      irq_active_d = irq_active_q;
      case (state_q)
         IDLE: begin
            if (req != '0) begin
               irq_vector_d = sel_idx;
               int_sig_d    = 1'b1;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (int_ack) begin
               int_sig_d    = 1'b0;
               irq_active_d = 1'b1;
               state_d      = SERVICE;
            end
         end
         SERVICE: begin
            if (eoi) begin
               irq_active_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            int_sig_d    = 1'b0;
            irq_active_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         s1_q         <= '0;
         s2_q         <= '0;
         s3_q         <= '0;
         pending_q    <= '0;
         mask_q       <= '0;
         int_sig_q    <= 1'b0;
         irq_vector_q <= '0;
         irq_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         int_sig_q    <= int_sig_d;
         irq_vector_q <= irq_vector_d;
         irq_active_q <= irq_active_d;
      end
   end

   assign int_sig    = int_sig_q;
   assign irq_vector = irq_vector_q;
   assign irq_active = irq_active_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a behavioural model predicts outputs per cycle and
// each raised request; a monitor pops both queues and compares against the DUT.
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       int_ack;
   logic       eoi;
   logic       int_sig;
   logic [2:0] irq_vector;
   logic       irq_active;
   logic [7:0] pending;
   logic [7:0] mask;

   always #5 clk = ~clk;

   irq_controller #(.N_IRQ(8), .VEC_W(3)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .int_ack(int_ack), .eoi(eoi),
      .int_sig(int_sig), .irq_vector(irq_vector), .irq_active(irq_active),
      .pending(pending), .mask(mask)
   );

   typedef struct {
      logic       isig;
      logic [2:0] vec;
      logic       act;
      logic [7:0] pend;
      logic [7:0] msk;
   } snap_t;

   snap_t      exp_q[$];
   logic [2:0] vec_q[$];
   int         n_pass = 0;
   int         n_checks = 0;

   // Model: history of sampled irq_in values (newest first), pending set,
   // mask, and phase 0 = idle, 1 = waiting for ack, 2 = in handler.
   logic [7:0] hist[$];
   logic [7:0] m_pend, m_msk;
   logic [2:0] m_vec;
   logic       m_isig, m_act;
   int         m_phase;
   logic [7:0] cur_irq;

   function automatic void chk(input string name, input int unsigned got, input int unsigned want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
   endfunction

   task automatic step(input logic r, input logic [7:0] irq, input logic mwe,
                       input logic [7:0] wd, input logic ack, input logic e);
      logic [7:0] rise_m, req_m, low;
      @(negedge clk);
      rst = r; irq_in = irq; mask_we = mwe; mask_wdata = wd; int_ack = ack; eoi = e;
      if (r) begin
         hist = '{8'h00, 8'h00, 8'h00};
         m_pend = 8'h00; m_msk = 8'h00; m_vec = 3'd0;
         m_isig = 1'b0; m_act = 1'b0; m_phase = 0;
      end else begin
         // A line is seen as rising once its synchronised copy goes 0 -> 1.
         rise_m = hist[1] & ~hist[2];
         req_m  = m_pend & ~m_msk;
         if (m_phase == 1 && ack) m_pend = m_pend & ~(8'h01 << m_vec);
         m_pend = m_pend | rise_m;
         case (m_phase)
            0: if (req_m != 8'h00) begin
                  low = req_m & (~req_m + 8'd1);
                  m_vec = 3'($clog2(low));
                  m_isig = 1'b1; m_phase = 1;
                  vec_q.push_back(m_vec);
               end
            1: if (ack) begin m_isig = 1'b0; m_act = 1'b1; m_phase = 2; end
            default: if (e) begin m_act = 1'b0; m_phase = 0; end
         endcase
         if (mwe) m_msk = wd;
         hist.push_front(irq);
         void'(hist.pop_back());
      end
      exp_q.push_back('{isig: m_isig, vec: m_vec, act: m_act, pend: m_pend, msk: m_msk});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, cur_irq, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_ack();
      step(1'b0, cur_irq, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic do_eoi();
      step(1'b0, cur_irq, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic wr_mask(input logic [7:0] v);
      step(1'b0, cur_irq, 1'b1, v, 1'b0, 1'b0);
   endtask

   task automatic wait_phase(input int p);
      int k = 0;
      while (m_phase != p && k < 60) begin
         idle(1);
         k++;
      end
      if (m_phase != p) begin
         n_checks++;
         $display("FAIL wait_phase: got phase %0d expected %0d", m_phase, p);
      end
   endtask

   // Monitor: every cycle with a prediction is compared; a rising int_sig
   // additionally consumes one predicted request vector.
   initial begin
      snap_t e;
      logic  prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("int_sig", int_sig, e.isig);
            chk("irq_vector", irq_vector, e.vec);
            chk("irq_active", irq_active, e.act);
            chk("pending", pending, e.pend);
            chk("mask", mask, e.msk);
            if (int_sig === 1'b1 && prev !== 1'b1) begin
               if (vec_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL req_event: unexpected request vector %0d", irq_vector);
               end else begin
                  chk("req_vector", irq_vector, vec_q.pop_front());
               end
            end
            prev = int_sig;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
      int_ack = 1'b0; eoi = 1'b0; cur_irq = 8'h00;
      step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

      // Single request on line 2
      cur_irq = 8'h04; wait_phase(1); do_ack(); idle(2); do_eoi(); idle(2);
      cur_irq = 8'h00; idle(3);

      // Lines 5 and 7 together: 5 first, 7 right after eoi
      cur_irq = 8'hA0; wait_phase(1); do_ack(); idle(1); do_eoi();
      wait_phase(1); do_ack(); idle(1); do_eoi();
      cur_irq = 8'h00; idle(3);

      // Masked line stays pending until unmasked
      wr_mask(8'h02);
      cur_irq = 8'h02; idle(1); cur_irq = 8'h00; idle(20);
      wr_mask(8'h00); wait_phase(1); do_ack(); do_eoi(); idle(2);

      // Request frozen while a higher line arrives and the active line is masked
      cur_irq = 8'h08; wait_phase(1);
      cur_irq = 8'h09; idle(3); wr_mask(8'h08); idle(2);
      do_ack(); do_eoi(); wait_phase(1); do_ack(); do_eoi();
      wr_mask(8'h00); cur_irq = 8'h00; idle(3);

      // New edge on line 4 in the same cycle as its ack
      cur_irq = 8'h10; idle(1); cur_irq = 8'h00; wait_phase(1);
      cur_irq = 8'h10; idle(2); do_ack(); cur_irq = 8'h00; idle(1); do_eoi();
      wait_phase(1); do_ack(); do_eoi(); idle(2);

      // Stray strobes
      do_eoi(); do_ack(); idle(1);
      cur_irq = 8'h01; wait_phase(1); do_eoi(); idle(1); do_ack(); do_ack(); idle(1); do_eoi();
      cur_irq = 8'h00; idle(3);

      // Reset while in service with more lines pending
      cur_irq = 8'h01; wait_phase(1); do_ack(); cur_irq = 8'h00; idle(2);
      cur_irq = 8'h11; idle(1); cur_irq = 8'h00; idle(3);
      wr_mask(8'hF0); idle(1);
      step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(3);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, mwe, ack, e;
         logic [7:0] flip;
         r    = ($urandom_range(0, 499) == 0);
         mwe  = ($urandom_range(0, 29) == 0);
         ack  = ($urandom_range(0, 3) == 0);
         e    = ($urandom_range(0, 5) == 0);
         flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
         cur_irq = cur_irq ^ flip;
         step(r, cur_irq, mwe, 8'($urandom) & 8'($urandom), ack, e);
      end

      cur_irq = 8'h00; idle(3);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      chk("snapshots_drained", exp_q.size(), 0);
      chk("vectors_drained", vec_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
